// File: rtl/scrambler_if.sv
// scrambler_if: valid/ready word stream into the scrambler and scrambled word stream out of it
interface scrambler_if #(parameter int unsigned WS = 7);
  logic i_valid, o_ready, i_start, o_valid, i_ready, o_start;
  logic [WS-1:0] i_word, o_word;
  modport slave (input i_valid, i_start, i_word, i_ready, output o_ready, o_valid, o_start, o_word);
  modport master (output i_valid, i_start, i_word, i_ready, input o_ready, o_valid, o_start, o_word);
endinterface

// File: rtl/scrambler.sv
// scrambler: multiplicative LFSR scrambler, one registered word per accepted word; SCRAMBLER_SYNC_EN prefixes each frame with SYNC_WORD
module scrambler #(
  parameter int unsigned WS = 7,
  parameter int unsigned LN = 31,
  parameter logic [LN-1:0] TAPS = 31'h0000_2001,
  parameter logic [LN-1:0] INITIAL_FILL = {{(LN-1){1'b0}}, 1'b1},
  parameter logic [WS-1:0] SYNC_WORD = 7'h4E
) (
  input logic i_clk,
  input logic i_reset_n,
  scrambler_if.slave bus
);
  logic slot_free, accept, load_fill, data_start;
  logic o_valid_q, o_valid_d, o_start_q, o_start_d;
  logic [WS-1:0] o_word_q, o_word_d, y_w;
  logic [LN-1:0] sreg_q, sreg_d, s_w;
  assign slot_free = !o_valid_q || bus.i_ready;
  assign accept = bus.i_valid && bus.o_ready;
`ifdef SCRAMBLER_SYNC_EN
  typedef enum logic {S_DATA, S_HDR} state_t;
  state_t state_q, state_d;
  logic hdr_load;
  assign bus.o_ready = slot_free && (state_q == S_HDR || !bus.i_start);
  assign load_fill = state_q == S_HDR;
  assign data_start = 1'b0;
  assign hdr_load = state_q == S_DATA && bus.i_valid && bus.i_start && slot_free;
  // frame state register
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) state_q <= S_DATA;
    else state_q <= state_d;
  // a pending start word first emits the header, then is scrambled when accepted
  always_comb state_d = hdr_load ? S_HDR : (state_q == S_HDR && accept) ? S_DATA : state_q;
`else
  logic unused_sync;
  assign unused_sync = ^SYNC_WORD;
  assign bus.o_ready = slot_free;
  assign load_fill = bus.i_start;
  assign data_start = bus.i_start;
`endif
  // scramble one word bit by bit, first bit in time is i_word[0] and lands in y_w[WS-1]
  always_comb begin
    s_w = load_fill ? INITIAL_FILL : sreg_q;
    y_w = '0;
    for (int j = 0; j < WS; j++) begin
      y_w[WS-1-j] = bus.i_word[j] ^ (^({1'b0, s_w[LN-1:1]} & TAPS));
      s_w = {y_w[WS-1-j], s_w[LN-1:1]};
    end
  end
  // output slot: load on accept (or header), drain when downstream takes it, hold while stalled
  always_comb begin
    o_valid_d = accept ? 1'b1 : o_valid_q && !bus.i_ready;
    o_word_d = accept ? y_w : o_word_q;
    o_start_d = accept ? data_start : o_start_q && o_valid_d;
    sreg_d = accept ? s_w : sreg_q;
`ifdef SCRAMBLER_SYNC_EN
    o_valid_d = hdr_load ? 1'b1 : o_valid_d;
    o_word_d = hdr_load ? SYNC_WORD : o_word_d;
    o_start_d = hdr_load ? 1'b1 : o_start_d;
`endif
  end
  // output register and LFSR state
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      o_valid_q <= 1'b0;
      o_start_q <= 1'b0;
      o_word_q <= '0;
      sreg_q <= INITIAL_FILL;
    end else begin
      o_valid_q <= o_valid_d;
      o_start_q <= o_start_d;
      o_word_q <= o_word_d;
      sreg_q <= sreg_d;
    end
  assign bus.o_valid = o_valid_q;
  assign bus.o_start = o_start_q;
  assign bus.o_word = o_word_q;
endmodule

// File: tb/tb_scrambler.sv
// tb_scrambler: directed bench for scrambler (default build, or with SCRAMBLER_SYNC_EN defined)
module tb_scrambler;
  localparam logic [30:0] TAPS = 31'h0000_2001;
  localparam logic [30:0] FILL = 31'h1;
`ifdef SCRAMBLER_SYNC_EN
  localparam int SYNC = 1;
`else
  localparam int SYNC = 0;
`endif
  logic clk = 0, rst_n = 1, bp_on = 0;
  int total = 0, bad = 0;
  logic [7:0] got[$], exp_q[$];
  logic [6:0] sent[$];
  logic stall_q = 0;
  logic [7:0] stall_item = '0;
  scrambler_if #(.WS(7)) bus();
  scrambler dut (.i_clk(clk), .i_reset_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) if (bp_on) begin
    #1;
    bus.i_ready = 1'($urandom_range(0, 1));
  end
  always @(negedge clk) begin
    if (stall_q) begin
      total++;
      if (!(bus.o_valid === 1'b1 && {bus.o_start, bus.o_word} === stall_item)) begin
        bad++;
        $display("FAIL stall_hold got v=%b %h want v=1 %h", bus.o_valid, {bus.o_start, bus.o_word}, stall_item);
      end
    end
    if (rst_n && bus.o_valid === 1'b1 && bus.i_ready === 1'b1) got.push_back({bus.o_start, bus.o_word});
    stall_q = rst_n && bus.o_valid === 1'b1 && bus.i_ready === 1'b0;
    stall_item = {bus.o_start, bus.o_word};
  end
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  function automatic void expect_word(input logic s, input logic [6:0] w);
    if (SYNC != 0 && s) begin
      exp_q.push_back({1'b1, 7'h4E});
      exp_q.push_back({1'b0, w});
    end else exp_q.push_back({s, w});
  endfunction
  task automatic send(input logic [6:0] w, input logic s);
    int n = 0;
    bus.i_valid = 1; bus.i_word = w; bus.i_start = s;
    do begin @(negedge clk); n++; end while (bus.o_ready !== 1'b1 && n < 100);
    if (bus.o_ready !== 1'b1) begin
      total++; bad++;
      $display("FAIL send_timeout o_ready=%b want=1", bus.o_ready);
    end
    @(posedge clk); #1;
    bus.i_valid = 0; bus.i_start = 0;
  endtask
  task automatic test_reset;
    bus.i_valid = 0; bus.i_start = 0; bus.i_word = 0; bus.i_ready = 1;
    #2 rst_n = 0;
    repeat (2) @(posedge clk); #1;
    total++; if (bus.o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus.o_valid); end
    total++; if (bus.o_start !== 1'b0) begin bad++; $display("FAIL reset_start got=%b want=0", bus.o_start); end
    total++; if (bus.o_word !== 7'h00) begin bad++; $display("FAIL reset_word got=%h want=00", bus.o_word); end
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    total++; if (bus.o_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", bus.o_ready); end
  endtask
  task automatic test_zero;
    got.delete(); exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      send(7'h00, i == 0);
      expect_word(i == 0, 7'h00);
      total++;
      if (bus.o_valid !== 1'b1 || bus.o_word !== 7'h00) begin
        bad++; $display("FAIL zero_latency[%0d] got v=%b w=%h want v=1 w=00", i, bus.o_valid, bus.o_word);
      end
    end
    for (int c = 0; c < 400 && got.size() < exp_q.size(); c++) @(posedge clk);
    repeat (3) @(posedge clk); #1;
    total++; if (got.size() != exp_q.size()) begin bad++; $display("FAIL zero_count got=%0d want=%0d", got.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      total++;
      if (got[i] !== exp_q[i]) begin bad++; $display("FAIL zero_word[%0d] got=%h want=%h", i, got[i], exp_q[i]); end
    end
  endtask
  task automatic test_impulse;
    logic [6:0] in_w [6] = '{7'h01, 7'h00, 7'h00, 7'h00, 7'h00, 7'h01};
    logic [6:0] out_w [6] = '{7'h40, 7'h00, 7'h08, 7'h00, 7'h11, 7'h40};
    got.delete(); exp_q.delete();
    for (int i = 0; i < 6; i++) begin
      send(in_w[i], i == 0 || i == 5);
      expect_word(i == 0 || i == 5, out_w[i]);
      total++;
      if (bus.o_word !== out_w[i]) begin bad++; $display("FAIL impulse_now[%0d] got=%h want=%h", i, bus.o_word, out_w[i]); end
    end
    for (int c = 0; c < 400 && got.size() < exp_q.size(); c++) @(posedge clk);
    repeat (3) @(posedge clk); #1;
    total++; if (got.size() != exp_q.size()) begin bad++; $display("FAIL impulse_count got=%0d want=%0d", got.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      total++;
      if (got[i] !== exp_q[i]) begin bad++; $display("FAIL impulse_word[%0d] got=%h want=%h", i, got[i], exp_q[i]); end
    end
  endtask
  task automatic test_start_flag;
    bus.i_valid = 1; bus.i_start = 1; bus.i_word = 7'h01; bus.i_ready = 1;
    #1;
`ifdef SCRAMBLER_SYNC_EN
    total++; if (bus.o_ready !== 1'b0) begin bad++; $display("FAIL hdr_ready got=%b want=0", bus.o_ready); end
    @(posedge clk); #1;
    total++;
    if ({bus.o_valid, bus.o_start, bus.o_word} !== {2'b11, 7'h4E}) begin
      bad++; $display("FAIL hdr_word got=%b%b%h want=11 4e", bus.o_valid, bus.o_start, bus.o_word);
    end
    total++; if (bus.o_ready !== 1'b1) begin bad++; $display("FAIL hdr_accept_ready got=%b want=1", bus.o_ready); end
`else
    total++; if (bus.o_ready !== 1'b1) begin bad++; $display("FAIL start_ready got=%b want=1", bus.o_ready); end
`endif
    @(posedge clk); #1;
    total++;
    if ({bus.o_valid, bus.o_start, bus.o_word} !== {1'b1, SYNC == 0, 7'h40}) begin
      bad++; $display("FAIL start_word got=%b%b%h want=1%b 40", bus.o_valid, bus.o_start, bus.o_word, SYNC == 0);
    end
    bus.i_valid = 0; bus.i_start = 0;
    repeat (2) @(posedge clk); #1;
  endtask
  task automatic test_back_to_back;
    time t0;
    int cycles, k;
    logic [30:0] d;
    logic [6:0] w, x;
    got.delete(); sent.delete();
    t0 = $time;
    for (int i = 0; i < 60; i++) begin
      w = 7'($urandom_range(0, 127));
      sent.push_back(w);
      send(w, i == 0 || i == 30);
    end
    cycles = int'(($time - t0) / 10);
    total++; if (cycles != 60 + 2 * SYNC) begin bad++; $display("FAIL throughput got=%0d want=%0d", cycles, 60 + 2 * SYNC); end
    for (int c = 0; c < 400 && got.size() < 60 + 2 * SYNC; c++) @(posedge clk);
    repeat (3) @(posedge clk); #1;
    total++; if (got.size() != 60 + 2 * SYNC) begin bad++; $display("FAIL b2b_count got=%0d want=%0d", got.size(), 60 + 2 * SYNC); end
    d = FILL; k = 0;
    foreach (got[i]) begin
      w = got[i][6:0];
      if (got[i][7]) d = FILL;
      if (!(SYNC != 0 && got[i][7])) begin
        for (int j = 0; j < 7; j++) begin
          x[j] = w[6-j] ^ (^({1'b0, d[30:1]} & TAPS));
          d = {w[6-j], d[30:1]};
        end
        total++;
        if (k >= sent.size() || x !== sent[k]) begin bad++; $display("FAIL loopback[%0d] got=%h want=%h", k, x, sent[k]); end
        k++;
      end
    end
  endtask
  task automatic test_backpressure;
    logic [6:0] out_w [5] = '{7'h40, 7'h00, 7'h08, 7'h00, 7'h11};
    got.delete(); exp_q.delete();
    bp_on = 1;
    for (int i = 0; i < 5; i++) begin
      send(i == 0 ? 7'h01 : 7'h00, i == 0);
      expect_word(i == 0, out_w[i]);
    end
    for (int c = 0; c < 400 && got.size() < exp_q.size(); c++) @(posedge clk);
    bp_on = 0;
    @(posedge clk); #2;
    bus.i_ready = 1;
    repeat (4) @(posedge clk); #1;
    total++; if (got.size() != exp_q.size()) begin bad++; $display("FAIL bp_count got=%0d want=%0d", got.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      total++;
      if (got[i] !== exp_q[i]) begin bad++; $display("FAIL bp_word[%0d] got=%h want=%h", i, got[i], exp_q[i]); end
    end
  endtask
  task automatic test_async_reset;
    got.delete(); exp_q.delete();
    send(7'h01, 1);
    send(7'h05, 0);
    #1 rst_n = 0;
    #1;
    total++; if (bus.o_valid !== 1'b0) begin bad++; $display("FAIL async_valid got=%b want=0", bus.o_valid); end
    total++; if (bus.o_start !== 1'b0) begin bad++; $display("FAIL async_start got=%b want=0", bus.o_start); end
    total++; if (bus.o_word !== 7'h00) begin bad++; $display("FAIL async_word got=%h want=00", bus.o_word); end
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    got.delete();
    send(7'h01, 1);
    expect_word(1'b1, 7'h40);
    for (int c = 0; c < 400 && got.size() < exp_q.size(); c++) @(posedge clk);
    repeat (3) @(posedge clk); #1;
    total++; if (got.size() != exp_q.size()) begin bad++; $display("FAIL async_count got=%0d want=%0d", got.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      total++;
      if (got[i] !== exp_q[i]) begin bad++; $display("FAIL async_word_after[%0d] got=%h want=%h", i, got[i], exp_q[i]); end
    end
  endtask
  initial begin
    test_reset;
    test_zero;
    test_impulse;
    test_start_flag;
    test_back_to_back;
    test_backpressure;
    test_async_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
